// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit order,
// active-high hex glyphs and a width helper.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Segment bit order: bit0 = a ... bit6 = g.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam seg_t SEG_HEX_0 = 7'h3F;
  localparam seg_t SEG_HEX_1 = 7'h06;
  localparam seg_t SEG_HEX_2 = 7'h5B;
  localparam seg_t SEG_HEX_3 = 7'h4F;
  localparam seg_t SEG_HEX_4 = 7'h66;
  localparam seg_t SEG_HEX_5 = 7'h6D;
  localparam seg_t SEG_HEX_6 = 7'h7D;
  localparam seg_t SEG_HEX_7 = 7'h07;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h6F;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h7C;
  localparam seg_t SEG_HEX_C = 7'h39;
  localparam seg_t SEG_HEX_D = 7'h5E;
  localparam seg_t SEG_HEX_E = 7'h79;
  localparam seg_t SEG_HEX_F = 7'h71;

  // Ceiling log2, used to size counters from their terminal counts.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output seg_t             seg_c_o
);

  always_comb begin
    seg_c_o = SEG_HEX_0;
    case (nibble_i)
      4'h0: seg_c_o = SEG_HEX_0;
      4'h1: seg_c_o = SEG_HEX_1;
      4'h2: seg_c_o = SEG_HEX_2;
      4'h3: seg_c_o = SEG_HEX_3;
      4'h4: seg_c_o = SEG_HEX_4;
      4'h5: seg_c_o = SEG_HEX_5;
      4'h6: seg_c_o = SEG_HEX_6;
      4'h7: seg_c_o = SEG_HEX_7;
      4'h8: seg_c_o = SEG_HEX_8;
      4'h9: seg_c_o = SEG_HEX_9;
      4'hA: seg_c_o = SEG_HEX_A;
      4'hB: seg_c_o = SEG_HEX_B;
      4'hC: seg_c_o = SEG_HEX_C;
      4'hD: seg_c_o = SEG_HEX_D;
      4'hE: seg_c_o = SEG_HEX_E;
      4'hF: seg_c_o = SEG_HEX_F;
      default: seg_c_o = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with dead time, blanking and a
// frame-synchronous load handshake so displayed values never tear.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLANK_TICKS = 500,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp,
  input  logic [NUM_DIGITS-1:0]       blank_en,
  input  logic                        lz_blank,
  input  logic                        load,
  output logic                        load_ack,
  output logic [SEG_W-1:0]            segments,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       seven_segs,
  output logic                        frame_tick
);

  localparam int unsigned TICK_W = clog2(DIGIT_TICKS);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W  = NIB_W * NUM_DIGITS;

  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{ACTIVE_LOW}};

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      stage_val_q, stage_val_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
  logic [NUM_DIGITS-1:0] stage_blank_q, stage_blank_d;
  logic                  pending_q, pending_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic                  commit_q, commit_d;

  logic [NUM_DIGITS-1:0] seven_segs_q, seven_segs_d;
  logic [SEG_W-1:0]      segments_q, segments_d;
  logic                  dp_out_q, dp_out_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  load_ack_q, load_ack_d;

  logic                  slot_end_c, frame_end_c, in_dead_c, anode_on_c;
  logic [NIB_W-1:0]      cur_nib_c;
  logic                  cur_dp_c, cur_dark_c, zero_run_c;
  logic [NUM_DIGITS-1:0] lz_dark_c;
  seg_t                  seg_pat_c;

  assign slot_end_c  = (tick_q == TICK_LAST);
  assign frame_end_c = slot_end_c && (idx_q == IDX_LAST);

  // Scan position: tick within slot, then digit index.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    idx_d  = idx_q;
    if (slot_end_c) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Staging collects loads; the shadow only changes at the frame boundary.
  always_comb begin
    stage_val_d    = stage_val_q;
    stage_dp_d     = stage_dp_q;
    stage_blank_d  = stage_blank_q;
    pending_d      = pending_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    commit_d       = 1'b0;
    if (frame_end_c) begin
      if (load) begin
        shadow_val_d   = value;
        shadow_dp_d    = dp;
        shadow_blank_d = blank_en;
      end else if (pending_q) begin
        shadow_val_d   = stage_val_q;
        shadow_dp_d    = stage_dp_q;
        shadow_blank_d = stage_blank_q;
      end
      pending_d = 1'b0;
      commit_d  = load || pending_q;
    end else if (load) begin
      stage_val_d   = value;
      stage_dp_d    = dp;
      stage_blank_d = blank_en;
      pending_d     = 1'b1;
    end
  end

  generate
    if (BLANK_TICKS == 0) begin : g_no_dead
      assign in_dead_c = 1'b0;
    end else begin : g_dead
      assign in_dead_c = (tick_q < TICK_W'(BLANK_TICKS));
    end
  endgenerate

  // Leading-zero run from the most significant digit down; digit 0 never joins it.
  always_comb begin
    zero_run_c = lz_blank;
    lz_dark_c  = '0;
    cur_nib_c  = '0;
    cur_dp_c   = 1'b0;
    cur_dark_c = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run_c   = zero_run_c && (shadow_val_q[NIB_W*i +: NIB_W] == '0);
      lz_dark_c[i] = zero_run_c;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib_c  = shadow_val_q[NIB_W*i +: NIB_W];
        cur_dp_c   = shadow_dp_q[i];
        cur_dark_c = shadow_blank_q[i] | lz_dark_c[i];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nib_c),
    .seg_c_o  (seg_pat_c)
  );

  assign anode_on_c = !in_dead_c && !cur_dark_c;

  always_comb begin
    seven_segs_d = (anode_on_c ? (NUM_DIGITS'(1) << idx_q) : '0) ^ AN_OFF;
    segments_d   = (anode_on_c ? SEG_W'(seg_pat_c) : '0) ^ SEG_OFF;
    dp_out_d     = (anode_on_c & cur_dp_c) ^ ACTIVE_LOW;
    frame_tick_d = (tick_q == '0) && (idx_q == '0);
    load_ack_d   = commit_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_q         <= '0;
      idx_q          <= '0;
      stage_val_q    <= '0;
      stage_dp_q     <= '0;
      stage_blank_q  <= '0;
      pending_q      <= 1'b0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      commit_q       <= 1'b0;
      seven_segs_q   <= AN_OFF;
      segments_q     <= SEG_OFF;
      dp_out_q       <= ACTIVE_LOW;
      frame_tick_q   <= 1'b0;
      load_ack_q     <= 1'b0;
    end else begin
      tick_q         <= tick_d;
      idx_q          <= idx_d;
      stage_val_q    <= stage_val_d;
      stage_dp_q     <= stage_dp_d;
      stage_blank_q  <= stage_blank_d;
      pending_q      <= pending_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      commit_q       <= commit_d;
      seven_segs_q   <= seven_segs_d;
      segments_q     <= segments_d;
      dp_out_q       <= dp_out_d;
      frame_tick_q   <= frame_tick_d;
      load_ack_q     <= load_ack_d;
    end
  end

  assign seven_segs = seven_segs_q;
  assign segments   = segments_q;
  assign dp_out     = dp_out_q;
  assign frame_tick = frame_tick_q;
  assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized self-checking bench for seven_seg_scan against a frame-position
// reference model (4 digits, 8 ticks per slot, 2 dead ticks, active-low).
module tb_seven_seg_scan;

  localparam int ND    = 4;
  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int FRAME = ND * DT;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank_en;
  logic        lz_blank;
  logic        load;
  logic        load_ack;
  logic [6:0]  segments;
  logic        dp_out;
  logic [3:0]  seven_segs;
  logic        frame_tick;

  seven_seg_scan #(
    .NUM_DIGITS  (ND),
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .value      (value),
    .dp         (dp),
    .blank_en   (blank_en),
    .lz_blank   (lz_blank),
    .load       (load),
    .load_ack   (load_ack),
    .segments   (segments),
    .dp_out     (dp_out),
    .seven_segs (seven_segs),
    .frame_tick (frame_tick)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles since release, the displayed data and the pending load.
  int          s;
  logic [15:0] m_val, st_val;
  logic [3:0]  m_dp, m_bl, st_dp, st_bl;
  bit          m_pend, m_ack;
  int          ack_seen, last_ft;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  task automatic model_reset();
    s = 0; m_val = '0; m_dp = '0; m_bl = '0;
    st_val = '0; st_dp = '0; st_bl = '0;
    m_pend = 1'b0; m_ack = 1'b0; last_ft = -1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_an"},  32'(seven_segs), 32'h0000_000F);
    check({tag, "_seg"}, 32'(segments),   32'h0000_007F);
    check({tag, "_dp"},  32'(dp_out),     32'h1);
    check({tag, "_ft"},  32'(frame_tick), 32'h0);
    check({tag, "_ack"}, 32'(load_ack),   32'h0);
  endtask

  // One clock: predict the registered outputs of the current frame position.
  task automatic step();
    int p, d, t;
    bit on;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft, e_ack;
    p = s % FRAME;
    d = p / DT;
    t = p % DT;
    on = (t >= BT) && !m_bl[d] && !(lz_blank && d != 0 && (m_val >> (4*d)) == 16'h0);
    e_an  = on ? ~(4'b0001 << d) : 4'hF;
    e_seg = on ? ~glyph(m_val[4*d +: 4]) : 7'h7F;
    e_dp  = !(on && m_dp[d]);
    e_ft  = (p == 0);
    e_ack = m_ack;
    m_ack = 1'b0;
    if (p == FRAME - 1) begin
      if (load) begin
        m_val = value; m_dp = dp; m_bl = blank_en; m_ack = 1'b1;
      end else if (m_pend) begin
        m_val = st_val; m_dp = st_dp; m_bl = st_bl; m_ack = 1'b1;
      end
      m_pend = 1'b0;
    end else if (load) begin
      st_val = value; st_dp = dp; st_bl = blank_en; m_pend = 1'b1;
    end
    @(posedge sys_clk);
    #1;
    s++;
    check("anodes",     32'(seven_segs), 32'(e_an));
    check("segments",   32'(segments),   32'(e_seg));
    check("dp_out",     32'(dp_out),     32'(e_dp));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    check("load_ack",   32'(load_ack),   32'(e_ack));
    if (load_ack === 1'b1) ack_seen++;
    if (frame_tick === 1'b1) begin
      if (last_ft >= 0) check("ft_period", 32'(s - last_ft), 32'(FRAME));
      last_ft = s;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (s % FRAME) != pos; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank_en = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    value = '0; dp = '0; blank_en = '0; lz_blank = 1'b0; load = 1'b0;
    sys_rst_n = 1'b0;
    model_reset();
    ack_seen = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_idle("reset");
    sys_rst_n = 1'b1;

    // Scan order and frame period with an all-zero display.
    run(2 * FRAME);

    // Decode of mixed glyphs.
    run(5);
    do_load(16'h1A0F, 4'b0000, 4'b0000);
    run_to(0);
    run(FRAME);

    // Two loads in one frame: only the last becomes visible, with one ack.
    run_to(10);
    ack_seen = 0;
    do_load(16'h1234, 4'b0000, 4'b0000);
    step();
    do_load(16'h5678, 4'b0000, 4'b0000);
    run_to(0);
    run(FRAME);
    check("single_ack", 32'(ack_seen), 32'd1);

    // Leading-zero suppression hides the dp of a suppressed digit.
    lz_blank = 1'b1;
    do_load(16'h0005, 4'b0010, 4'b0000);
    run_to(0);
    run(FRAME);
    lz_blank = 1'b0;
    run(FRAME);

    // Load on the boundary cycle commits immediately.
    run_to(FRAME - 1);
    ack_seen = 0;
    do_load(16'hBEEF, 4'b1001, 4'b0100);
    run(FRAME);
    check("boundary_ack", 32'(ack_seen), 32'd1);

    // Random loads, blanking and lz toggling at random times.
    for (int k = 0; k < 40; k++) begin
      run($urandom_range(0, 45));
      if ($urandom_range(0, 3) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 1) == 1)
        do_load(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
    end
    run(FRAME);

    // Asynchronous reset during digit 2's active window.
    lz_blank = 1'b0;
    do_load(16'h9876, 4'b0100, 4'b0000);
    run_to(0);
    run(2 * DT + 4);
    check("pre_rst_an", 32'(seven_segs), 32'h0000_000B);
    sys_rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    repeat (2) @(posedge sys_clk);
    #1;
    check_idle("rst_hold");
    sys_rst_n = 1'b1;
    model_reset();
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised, time-multiplexed seven-segment display driver for the board's common-anode displays. It replaces the fixed 4-digit pattern driver. It scans NUM_DIGITS digits, decodes 4-bit hex nibbles to segment patterns, and drives per-digit decimal points. It also provides per-digit and leading-zero blanking, an anti-ghosting dead time, and a frame-synchronous load handshake so displayed values never tear mid-frame. It sits between the counting/timekeeping logic and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
DIGIT_TICKS, 50000, sys_clk cycles per digit slot (1 ms at 50 MHz); legal values are >= 2.
BLANK_TICKS, 500, cycles at the start of each slot with all anodes off; legal range 0 <= BLANK_TICKS < DIGIT_TICKS.
ACTIVE_LOW, 1, 1 means segment and anode outputs are active-low (board default); 0 means active-high.

Ports:
sys_clk  in  1  system clock (50 MHz)
sys_rst_n  in  1  asynchronous, active-low reset
value  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i, and digit 0 is rightmost
dp  in  NUM_DIGITS  decimal point request per digit
blank_en  in  NUM_DIGITS  1 forces digit i dark
lz_blank  in  1  enables leading-zero suppression
load  in  1  one-cycle strobe: capture value/dp/blank_en for display
load_ack  out  1  one-cycle pulse when the captured data becomes visible
segments  out  7  segment drive; bit0=a ... bit6=g
dp_out  out  1  decimal point drive
seven_segs  out  NUM_DIGITS  anode enables; bit i = digit i
frame_tick  out  1  one-cycle pulse at the start of each frame (digit 0 slot)

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - tick counter = 0, digit index = 0.
  - staging and shadow registers (value/dp/blank_en) = 0; pending = 0.
  - All outputs at their inactive level: every seven_segs bit off, every segment off, dp_out off, frame_tick = 0, load_ack = 0.
  - Release takes effect on the next rising sys_clk edge.
- Tick counter:
  - Counts 0..DIGIT_TICKS-1, then wraps to 0.
  - On wrap, digit index increments; from NUM_DIGITS-1 it wraps to 0.
  - When NUM_DIGITS=1, the index stays at 0.
- frame_tick pulses for exactly one cycle, registered, in the cycle after the digit index becomes 0.
- Output timing: all outputs are registered with one cycle of latency from the tick/index state.
- Dead time: while tick < BLANK_TICKS, every anode is off; segments may hold any value.
- Active window: for tick >= BLANK_TICKS, exactly one anode (the current digit) is on, unless that digit is blanked.
- Blanking: digit i is dark (anode off) if either of these holds:
  - shadow blank_en[i] = 1, or
  - lz_blank = 1 and digits NUM_DIGITS-1 down to i all hold shadow nibble 0.
  - Digit 0 is never suppressed by lz_blank.
- Decode: hex 0-F map to standard patterns. Examples in active-high form: 0 = 0111111, 1 = 0000110, 8 = 1111111, F = 1110001. When ACTIVE_LOW=1, all outputs are inverted.
- dp_out is on only while the digit's anode is on and shadow dp[i] = 1.
- Load handshake:
  - load=1 copies value/dp/blank_en into staging and sets pending.
  - At the next frame boundary (digit index wrapping to 0), staging is copied to shadow, pending is cleared, and load_ack pulses in the same cycle as frame_tick.
  - Multiple loads before the boundary: the last one wins, and only one load_ack is issued.
  - load in the same cycle as the boundary: the input data goes directly to shadow and load_ack pulses.
  - Without any load, shadow holds its contents indefinitely.
- Reset mid-frame: outputs go to the inactive level immediately, pending data is discarded, and scanning restarts at digit 0, tick 0.
- lz_blank is sampled live, not shadowed, and takes effect within one cycle.

Decomposition:
- Package seven_seg_pkg holds:
  - localparam segment-pattern constants for hex 0-F, active-high, bit0=a;
  - the bit-order definition;
  - a clog2 helper used to size the tick counter and digit index.
- Sub-module hex_to_seg: combinational nibble to 7-bit active-high pattern. It is instantiated once, on the current digit's nibble. Polarity inversion stays in the parent.

Test Plan:
- Reset and scan order (DIGIT_TICKS=8, BLANK_TICKS=2, NUM_DIGITS=4):
  - Stimulus: hold reset, then release.
  - Response: during reset, seven_segs=1111 and segments=1111111.
  - Response: after release, the anode patterns 1110, 1101, 1011, 0111 each assert for 6 cycles following 2 dark cycles.
  - Response: frame_tick has a period of 32 cycles.
- Decode:
  - Stimulus: load value=16'h1A0F, all dp/blank_en=0.
  - Response: after load_ack, active-low segments are: digit3 = 1111001 ("1"), digit2 = 0001000 ("A"), digit1 = 1000000 ("0"), digit0 = 0001110 ("F").
- Frame-synchronous load:
  - Stimulus: load 16'h1234 mid-frame, then 16'h5678 two cycles later.
  - Response: 1234 is never displayed; 5678 appears from digit 0 of the next frame.
  - Response: a single load_ack, coincident with frame_tick.
- Blanking and dp:
  - Stimulus: value=16'h0005, lz_blank=1, dp=0010, blank_en=0000.
  - Response: digits 3 and 2 are dark; digit 1 is dark (leading zero), so dp_out is never on; digit 0 shows "5".
  - Stimulus: set lz_blank=0.
  - Response: digit 1 shows "0" with dp_out on.
- Boundary and reset:
  - Stimulus: load coincident with the frame boundary.
  - Response: immediate update and load_ack.
  - Stimulus: assert sys_rst_n=0 during digit 2's slot.
  - Response: outputs are inactive within the same cycle, shadow is cleared, and the scan resumes at digit 0 after release.
